// File: rtl/kuznechik_pkg.sv
// kuznechik_pkg
//   Shared Kuznechik (GOST R 34.12-2015) definitions used by the key expander
//   and the cipher datapath:
//     - FSM state encoding of the key expander
//     - GF(2^8) field polynomial and linear-transform coefficient list
//     - names of the ROM image files loaded by the cipher
//     - S-box table, GF multiply and the round-constant ROM contents.
//   The image files hold exactly the values of SBOX and gf_mul(x, coef)
//   below. This lets both blocks address identical data.
package kuznechik_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OUT  = 3'd1;
  localparam logic [2:0] ST_X    = 3'd2;
  localparam logic [2:0] ST_S    = 3'd3;
  localparam logic [2:0] ST_L    = 3'd4;

  localparam int NUM_BYTES = 16;
  localparam int NUM_RC    = 32;

  // x^8 + x^7 + x^6 + x + 1, with the x^8 term implied
  localparam logic [7:0] GF_POLY = 8'hC3;

  // Element [15] multiplies byte [127:120], element [0] multiplies byte [7:0]
  localparam logic [NUM_BYTES-1:0][7:0] L_COEF = {
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1,   8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  localparam string SBOX_FILE  = "S_box.mem";
  localparam string L_16_FILE  = "L_16.mem";
  localparam string L_32_FILE  = "L_32.mem";
  localparam string L_133_FILE = "L_133.mem";
  localparam string L_148_FILE = "L_148.mem";
  localparam string L_192_FILE = "L_192.mem";
  localparam string L_194_FILE = "L_194.mem";
  localparam string L_251_FILE = "L_251.mem";
  localparam string C_FILE     = "C_const.mem";

  localparam logic [7:0] SBOX [256] = '{
    8'hfc, 8'hee, 8'hdd, 8'h11, 8'hcf, 8'h6e, 8'h31, 8'h16, 8'hfb, 8'hc4, 8'hfa, 8'hda, 8'h23, 8'hc5, 8'h04, 8'h4d,
    8'he9, 8'h77, 8'hf0, 8'hdb, 8'h93, 8'h2e, 8'h99, 8'hba, 8'h17, 8'h36, 8'hf1, 8'hbb, 8'h14, 8'hcd, 8'h5f, 8'hc1,
    8'hf9, 8'h18, 8'h65, 8'h5a, 8'he2, 8'h5c, 8'hef, 8'h21, 8'h81, 8'h1c, 8'h3c, 8'h42, 8'h8b, 8'h01, 8'h8e, 8'h4f,
    8'h05, 8'h84, 8'h02, 8'hae, 8'he3, 8'h6a, 8'h8f, 8'ha0, 8'h06, 8'h0b, 8'hed, 8'h98, 8'h7f, 8'hd4, 8'hd3, 8'h1f,
    8'heb, 8'h34, 8'h2c, 8'h51, 8'hea, 8'hc8, 8'h48, 8'hab, 8'hf2, 8'h2a, 8'h68, 8'ha2, 8'hfd, 8'h3a, 8'hce, 8'hcc,
    8'hb5, 8'h70, 8'h0e, 8'h56, 8'h08, 8'h0c, 8'h76, 8'h12, 8'hbf, 8'h72, 8'h13, 8'h47, 8'h9c, 8'hb7, 8'h5d, 8'h87,
    8'h15, 8'ha1, 8'h96, 8'h29, 8'h10, 8'h7b, 8'h9a, 8'hc7, 8'hf3, 8'h91, 8'h78, 8'h6f, 8'h9d, 8'h9e, 8'hb2, 8'hb1,
    8'h32, 8'h75, 8'h19, 8'h3d, 8'hff, 8'h35, 8'h8a, 8'h7e, 8'h6d, 8'h54, 8'hc6, 8'h80, 8'hc3, 8'hbd, 8'h0d, 8'h57,
    8'hdf, 8'hf5, 8'h24, 8'ha9, 8'h3e, 8'ha8, 8'h43, 8'hc9, 8'hd7, 8'h79, 8'hd6, 8'hf6, 8'h7c, 8'h22, 8'hb9, 8'h03,
    8'he0, 8'h0f, 8'hec, 8'hde, 8'h7a, 8'h94, 8'hb0, 8'hbc, 8'hdc, 8'he8, 8'h28, 8'h50, 8'h4e, 8'h33, 8'h0a, 8'h4a,
    8'ha7, 8'h97, 8'h60, 8'h73, 8'h1e, 8'h00, 8'h62, 8'h44, 8'h1a, 8'hb8, 8'h38, 8'h82, 8'h64, 8'h9f, 8'h26, 8'h41,
    8'had, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5e, 8'h55, 8'h2f, 8'h8c, 8'ha3, 8'ha5, 8'h7d, 8'h69, 8'hd5, 8'h95, 8'h3b,
    8'h07, 8'h58, 8'hb3, 8'h40, 8'h86, 8'hac, 8'h1d, 8'hf7, 8'h30, 8'h37, 8'h6b, 8'he4, 8'h88, 8'hd9, 8'he7, 8'h89,
    8'he1, 8'h1b, 8'h83, 8'h49, 8'h4c, 8'h3f, 8'hf8, 8'hfe, 8'h8d, 8'h53, 8'haa, 8'h90, 8'hca, 8'hd8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'ha4, 8'h2d, 8'h2b, 8'h09, 8'h5b, 8'hcb, 8'h9b, 8'h25, 8'hd0, 8'hbe, 8'he5, 8'h6c, 8'h52,
    8'h59, 8'ha6, 8'h74, 8'hd2, 8'he6, 8'hf4, 8'hb4, 8'hc0, 8'hd1, 8'h66, 8'haf, 8'hc2, 8'h39, 8'h4b, 8'h63, 8'hb6
  };

  // Shift-and-reduce multiply in GF(2^8)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] lin(input logic [127:0] v);
    logic [7:0] acc;
    acc = '0;
    for (int k = 0; k < NUM_BYTES; k++) acc = acc ^ gf_mul(v[k*8 +: 8], L_COEF[k]);
    return acc;
  endfunction

  // Full L = 16 R steps. Used only at elaboration time to build the ROM.
  function automatic logic [127:0] l_full(input logic [127:0] v);
    logic [127:0] s;
    s = v;
    for (int r = 0; r < NUM_BYTES; r++) s = {lin(s), s[127:8]};
    return s;
  endfunction

  // Entry j holds C[j+1] = L(Vec128(j+1))
  typedef logic [NUM_RC-1:0][127:0] rc_rom_t;

  function automatic rc_rom_t gen_rc_rom();
    rc_rom_t rom;
    for (int j = 0; j < NUM_RC; j++) rom[j] = l_full(128'(j + 1));
    return rom;
  endfunction

  localparam rc_rom_t RC_ROM = gen_rc_rom();

endpackage

// File: rtl/kuznechik_r_step.sv
// kuznechik_r_step
//   One combinational R step of the Kuznechik linear layer.
//   The output is {lin(state), state[127:8]}.
//   The cipher's L phase uses the same module.
//   Ports:
//     i_state  in  128  current state
//     o_state  out 128  state after one R step
module kuznechik_r_step
  import kuznechik_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  logic [NUM_BYTES-1:0][7:0] w_prod;
  logic [7:0]                w_lin;

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_byte
    assign w_prod[g] = gf_mul(i_state[g*8 +: 8], L_COEF[g]);
  end

  always_comb begin
    w_lin = '0;
    for (int k = 0; k < NUM_BYTES; k++) w_lin = w_lin ^ w_prod[k];
  end

  assign o_state = {w_lin, i_state[127:8]};

endmodule

// File: rtl/kuznechik_key_expander.sv
// kuznechik_key_expander
//   Expands a 256-bit master key into the ten 128-bit Kuznechik round keys.
//   It streams the keys to the cipher key store over a valid/ready port.
//   Each Feistel iteration takes 18 cycles: X (1), S (1) and L (16 R steps).
//   After every 8 iterations the block presents the current (a1, a0) pair.
//   Ports:
//     clk_i         in   1    clock, rising edge
//     resetn_i      in   1    async active-low reset
//     key_valid_i   in   1    master-key load request (ignored while busy)
//     key_i         in   256  master key {K1, K2}
//     busy_o        out  1    schedule in progress
//     rk_valid_o    out  1    round key presented
//     rk_ready_i    in   1    consumer accepts the round key
//     rk_idx_o      out  4    round key index 0..9
//     rk_o          out  128  round key value
//     keys_ready_o  out  1    all ten keys delivered; cleared on next load
module kuznechik_key_expander
  import kuznechik_pkg::*;
(
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         key_valid_i,
  input  logic [255:0] key_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [3:0]   rk_idx_o,
  output logic [127:0] rk_o,
  output logic         keys_ready_o
);

  logic [2:0]   r_state;
  logic [127:0] r_a1, r_a0, r_t;
  logic [4:0]   r_iter;   // completed Feistel iterations; wraps after 32, unused then
  logic [3:0]   r_lcnt;
  logic [3:0]   r_idx;
  logic         r_keys_ready;

  logic [127:0] w_r_out;
  logic [127:0] w_sub;
  logic         w_xfer;

  kuznechik_r_step u_r_step (
    .i_state (r_t),
    .o_state (w_r_out)
  );

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_sbox
    assign w_sub[g*8 +: 8] = SBOX[r_t[g*8 +: 8]];
  end

  assign w_xfer = rk_valid_o & rk_ready_i;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state      <= ST_IDLE;
      r_a1         <= '0;
      r_a0         <= '0;
      r_t          <= '0;
      r_iter       <= '0;
      r_lcnt       <= '0;
      r_idx        <= '0;
      r_keys_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (key_valid_i) begin
          r_a1         <= key_i[255:128];
          r_a0         <= key_i[127:0];
          r_iter       <= '0;
          r_idx        <= '0;
          r_keys_ready <= 1'b0;
          r_state      <= ST_OUT;
        end
        ST_OUT: if (w_xfer) begin
          if (r_idx == 4'd9) begin
            r_keys_ready <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_idx <= r_idx + 4'd1;
            // odd index closes the pair; compute the next one
            if (r_idx[0]) r_state <= ST_X;
          end
        end
        ST_X: begin
          r_t     <= r_a1 ^ RC_ROM[r_iter];
          r_state <= ST_S;
        end
        ST_S: begin
          r_t     <= w_sub;
          r_lcnt  <= '0;
          r_state <= ST_L;
        end
        ST_L: begin
          r_t    <= w_r_out;
          r_lcnt <= r_lcnt + 4'd1;
          if (r_lcnt == 4'd15) begin
            r_a1    <= w_r_out ^ r_a0;
            r_a0    <= r_a1;
            r_iter  <= r_iter + 5'd1;
            r_state <= (r_iter[2:0] == 3'd7) ? ST_OUT : ST_X;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o       = (r_state != ST_IDLE);
  assign rk_valid_o   = (r_state == ST_OUT);
  assign rk_idx_o     = r_idx;
  // even index -> a1, odd index -> a0
  assign rk_o         = rk_valid_o ? (r_idx[0] ? r_a0 : r_a1) : '0;
  assign keys_ready_o = r_keys_ready;

endmodule

// File: tb/tb_kuznechik_key_expander.sv
// tb_kuznechik_key_expander
//   Random and known-answer checks of the key expander against a byte-level
//   model of the GOST R 34.12-2015 key schedule.
module tb_kuznechik_key_expander;

  logic         clk_i = 1'b0;
  logic         resetn_i;
  logic         key_valid_i;
  logic [255:0] key_i;
  logic         busy_o, rk_valid_o, rk_ready_i, keys_ready_o;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [127:0] exp_k [10];
  logic [127:0] cap   [10];

  localparam logic [255:0] GOST_KEY =
    256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;

  int LC [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};

  byte unsigned PI [256] = '{
    252,238,221,17,207,110,49,22,251,196,250,218,35,197,4,77,
    233,119,240,219,147,46,153,186,23,54,241,187,20,205,95,193,
    249,24,101,90,226,92,239,33,129,28,60,66,139,1,142,79,
    5,132,2,174,227,106,143,160,6,11,237,152,127,212,211,31,
    235,52,44,81,234,200,72,171,242,42,104,162,253,58,206,204,
    181,112,14,86,8,12,118,18,191,114,19,71,156,183,93,135,
    21,161,150,41,16,123,154,199,243,145,120,111,157,158,178,177,
    50,117,25,61,255,53,138,126,109,84,198,128,195,189,13,87,
    223,245,36,169,62,168,67,201,215,121,214,246,124,34,185,3,
    224,15,236,222,122,148,176,188,220,232,40,80,78,51,10,74,
    167,151,96,115,30,0,98,68,26,184,56,130,100,159,38,65,
    173,69,70,146,39,94,85,47,140,163,165,125,105,213,149,59,
    7,88,179,64,134,172,29,247,48,55,107,228,136,217,231,137,
    225,27,131,73,76,63,248,254,141,83,170,144,202,216,133,97,
    32,113,103,164,45,43,9,91,203,155,37,208,190,229,108,82,
    89,166,116,210,230,244,180,192,209,102,175,194,57,75,99,182
  };

  kuznechik_key_expander dut (
    .clk_i        (clk_i),
    .resetn_i     (resetn_i),
    .key_valid_i  (key_valid_i),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .rk_valid_o   (rk_valid_o),
    .rk_ready_i   (rk_ready_i),
    .rk_idx_o     (rk_idx_o),
    .rk_o         (rk_o),
    .keys_ready_o (keys_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Carry-less product, then reduce modulo 0x1C3
  function automatic logic [7:0] m_mul(input logic [7:0] a, input int b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h1C3 << (i - 8));
    return p[7:0];
  endfunction

  // bytes kept MSB-first: b[0] = bits [127:120]
  function automatic logic [127:0] m_L(input logic [127:0] v);
    logic [7:0] b [16];
    logic [7:0] n;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) b[k] = v[127-8*k -: 8];
    for (int rnd = 0; rnd < 16; rnd++) begin
      n = '0;
      for (int k = 0; k < 16; k++) n = n ^ m_mul(b[k], LC[k]);
      for (int k = 15; k > 0; k--) b[k] = b[k-1];
      b[0] = n;
    end
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = b[k];
    return r;
  endfunction

  function automatic logic [127:0] m_S(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = PI[v[8*k +: 8]];
    return r;
  endfunction

  task automatic m_expand(input logic [255:0] key);
    logic [127:0] a1, a0, t;
    a1 = key[255:128];
    a0 = key[127:0];
    exp_k[0] = a1;
    exp_k[1] = a0;
    for (int i = 1; i <= 32; i++) begin
      t  = m_L(m_S(a1 ^ m_L(128'(i))));
      a0 = a0 ^ t;
      t  = a1;
      a1 = a0;
      a0 = t;
      if (i % 8 == 0) begin
        exp_k[i/4]     = a1;
        exp_k[i/4 + 1] = a0;
      end
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  // Called at a negedge with the DUT idle. It loads the key and streams all
  // keys out. mode: 0 = ready held, 1 = ready toggles, 2 = random ready.
  // inj_cyc: issue a competing load in that cycle. rst_cyc: abort by reset.
  task automatic run_keys(input logic [255:0] key, input int mode,
                          input int inj_cyc, input int rst_cyc);
    int           cyc, nxt;
    bit           stalled, rdy;
    logic [127:0] held_rk;
    logic [3:0]   held_idx;
    m_expand(key);
    key_i       = key;
    key_valid_i = 1'b1;
    rk_ready_i  = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    key_valid_i = 1'b0;
    chk("load_busy", 128'(busy_o), 128'd1);
    chk("load_kr_low", 128'(keys_ready_o), 128'd0);
    chk("load_valid", 128'(rk_valid_o), 128'd1);
    chk("load_idx0", 128'(rk_idx_o), 128'd0);
    chk("load_k1", rk_o, key[255:128]);
    cyc = 0; nxt = 0; stalled = 0; held_rk = '0; held_idx = '0;
    while (!keys_ready_o && cyc < 3000) begin
      if (cyc == rst_cyc) begin
        #2 resetn_i = 1'b0;
        #1;
        chk("arst_busy", 128'(busy_o), 128'd0);
        chk("arst_valid", 128'(rk_valid_o), 128'd0);
        chk("arst_kr", 128'(keys_ready_o), 128'd0);
        chk("arst_idx", 128'(rk_idx_o), 128'd0);
        chk("arst_rk", rk_o, 128'd0);
        rk_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        resetn_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk_i);
          chk("post_rst_valid", 128'(rk_valid_o), 128'd0);
          chk("post_rst_busy", 128'(busy_o), 128'd0);
        end
        return;
      end
      if (cyc == inj_cyc) begin
        key_valid_i = 1'b1;
        key_i       = rand256();
      end else begin
        key_valid_i = 1'b0;
      end
      if (rk_valid_o && stalled) begin
        chk("stall_rk", rk_o, held_rk);
        chk("stall_idx", 128'(rk_idx_o), 128'(held_idx));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rk_ready_i = rdy;
      stalled    = 1'b0;
      if (rk_valid_o && rdy) begin
        if (nxt < 10) begin
          chk($sformatf("idx_%0d", nxt), 128'(rk_idx_o), 128'(nxt));
          chk($sformatf("key_%0d", nxt), rk_o, exp_k[nxt]);
          cap[nxt] = rk_o;
        end else begin
          chk("extra_xfer", 128'(rk_idx_o), 128'hf);
        end
        nxt++;
      end else if (rk_valid_o) begin
        stalled  = 1'b1;
        held_rk  = rk_o;
        held_idx = rk_idx_o;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
    end
    key_valid_i = 1'b0;
    chk("done_kr", 128'(keys_ready_o), 128'd1);
    chk("done_nkeys", 128'(nxt), 128'd10);
    chk("done_busy", 128'(busy_o), 128'd0);
    chk("done_valid", 128'(rk_valid_o), 128'd0);
    if (mode == 0) chk("latency", 128'(cyc), 128'd586);
  endtask

  initial begin
    resetn_i    = 1'b1;
    key_valid_i = 1'b0;
    key_i       = '0;
    rk_ready_i  = 1'b0;
    #1 resetn_i = 1'b0;
    #1;
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_valid", 128'(rk_valid_o), 128'd0);
    chk("rst_kr", 128'(keys_ready_o), 128'd0);
    chk("rst_idx", 128'(rk_idx_o), 128'd0);
    chk("rst_rk", rk_o, 128'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    // load lands on the first rising edge after release
    resetn_i = 1'b1;
    run_keys(GOST_KEY, 0, -1, -1);
    chk("kat_idx0", cap[0], 128'h8899aabbccddeeff0011223344556677);
    chk("kat_idx2", cap[2], 128'hdb31485315694343228d6aef8cc78c44);
    chk("kat_idx9", cap[9], 128'h72e9dd7416bcf45b755dbaa88e4a4043);

    // back-to-back load right after keys_ready_o, with random backpressure
    run_keys(rand256(), 2, -1, -1);

    run_keys(GOST_KEY, 1, -1, -1);
    chk("tog_idx9", cap[9], 128'h72e9dd7416bcf45b755dbaa88e4a4043);

    run_keys(GOST_KEY, 0, 50, -1);
    chk("inj_idx2", cap[2], 128'hdb31485315694343228d6aef8cc78c44);

    run_keys(rand256(), 0, -1, 300);
    run_keys(rand256(), 0, -1, -1);
    run_keys(rand256(), 2, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
